// File: rtl/basic_cpu_ctrl_alu_if.sv
// rtl/basic_cpu_ctrl_alu_if.sv - register/strobe bundle between the control-ALU core and the datapath
//
// Groups everything except clk/rst.
//   Inputs to the core:   sc_inr, sc_clr, ir[15:0], r, ac[15:0], dr[15:0], inpr[7:0]
//   Outputs of the core:  s[2:0], t[7:0], d[7:0], i, ac_ld, ac_inr, ac_clr, alu_out[15:0], e
// modport slave  : the core (basic_cpu_ctrl_alu)
// modport master : whoever owns IR/DR/INPR/AC and the sequence-counter controls
interface basic_cpu_ctrl_alu_if;
  logic        sc_inr;
  logic        sc_clr;
  logic [15:0] ir;
  logic        r;
  logic [15:0] ac;
  logic [15:0] dr;
  logic [7:0]  inpr;
  logic [2:0]  s;
  logic [7:0]  t;
  logic [7:0]  d;
  logic        i;
  logic        ac_ld;
  logic        ac_inr;
  logic        ac_clr;
  logic [15:0] alu_out;
  logic        e;

  modport slave (
    input  sc_inr, sc_clr, ir, r, ac, dr, inpr,
    output s, t, d, i, ac_ld, ac_inr, ac_clr, alu_out, e
  );

  modport master (
    output sc_inr, sc_clr, ir, r, ac, dr, inpr,
    input  s, t, d, i, ac_ld, ac_inr, ac_clr, alu_out, e
  );
endinterface

// File: rtl/basic_cpu_ctrl_alu.sv
// rtl/basic_cpu_ctrl_alu.sv - sequence counter, instruction decode, AC control and AC-input ALU with E flip-flop
//
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset (s=0, e=0)
//   bus  : basic_cpu_ctrl_alu_if.slave (IR/DR/INPR/AC in, timing/decode/strobes/alu_out/e out)
// Optional feature macro: INTERRUPT_GATE_EN
//   defined   -> AC strobes and E updates suppressed while r=1
//   undefined -> r ignored
module basic_cpu_ctrl_alu (
  input  logic               clk,
  input  logic               rst,
  basic_cpu_ctrl_alu_if.slave bus
);

  logic [2:0]  s_q;
  logic        e_q;
  logic        e_d;
  logic        en;
  logic [11:0] b;
  logic        rr;
  logic        io;
  logic        op_and;
  logic        op_add;
  logic        op_lda;
  logic        op_cma;
  logic        op_cir;
  logic        op_cil;
  logic        op_inp;
  logic [16:0] sum;
  logic [15:0] alu_d;
  logic        unused_bits;

`ifdef INTERRUPT_GATE_EN
  assign en          = ~bus.r;
  assign unused_bits = ^bus.ir[4:0];
`else
  assign en          = 1'b1;
  assign unused_bits = ^{bus.ir[4:0], bus.r};
`endif

  // Sequence counter; 3-bit add wraps 7 -> 0 on its own.
  always_ff @(posedge clk) begin
    if (rst)             s_q <= 3'd0;
    else if (bus.sc_clr) s_q <= 3'd0;
    else if (bus.sc_inr) s_q <= s_q + 3'd1;
  end

  assign bus.s = s_q;
  assign bus.t = 8'h01 << s_q;
  assign bus.d = 8'h01 << bus.ir[14:12];
  assign bus.i = bus.ir[15];

  assign b  = bus.ir[11:0];
  assign rr = bus.d[7] & ~bus.i & bus.t[3];
  assign io = bus.d[7] &  bus.i & bus.t[3];

  // Operation selects are ungated; only strobes and E honour en.
  assign op_and = bus.d[0] & bus.t[5];
  assign op_add = bus.d[1] & bus.t[5];
  assign op_lda = bus.d[2] & bus.t[5];
  assign op_cma = rr & b[9];
  assign op_cir = rr & b[7];
  assign op_cil = rr & b[6];
  assign op_inp = io & b[11];

  assign bus.ac_clr = en & rr & b[11];
  assign bus.ac_inr = en & rr & b[5];
  assign bus.ac_ld  = en & (op_and | op_add | op_lda | op_cma | op_cir | op_cil | op_inp);

  assign sum = {1'b0, bus.ac} + {1'b0, bus.dr};

  always_comb begin
    alu_d = bus.ac;
    if      (op_and) alu_d = bus.ac & bus.dr;
    else if (op_add) alu_d = sum[15:0];
    else if (op_lda) alu_d = bus.dr;
    else if (op_cma) alu_d = ~bus.ac;
    else if (op_cir) alu_d = {e_q, bus.ac[15:1]};
    else if (op_cil) alu_d = {bus.ac[14:0], e_q};
    else if (op_inp) alu_d = {bus.ac[15:8], bus.inpr};
  end

  assign bus.alu_out = alu_d;

  // ADD lives at T5 and the register-reference ops at T3, so they never collide.
  always_comb begin
    e_d = e_q;
    if (en) begin
      if      (op_add)      e_d = sum[16];
      else if (rr & b[10])  e_d = 1'b0;
      else if (rr & b[8])   e_d = ~e_q;
      else if (op_cir)      e_d = bus.ac[0];
      else if (op_cil)      e_d = bus.ac[15];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) e_q <= 1'b0;
    else     e_q <= e_d;
  end

  assign bus.e = e_q;

endmodule

// File: tb/tb_basic_cpu_ctrl_alu.sv
// tb/tb_basic_cpu_ctrl_alu.sv - scoreboard bench for basic_cpu_ctrl_alu with directed and random stimulus
module tb_basic_cpu_ctrl_alu;

  typedef struct {
    logic [2:0]  s;
    logic [7:0]  t;
    logic [7:0]  d;
    logic        i;
    logic        ld;
    logic        inr;
    logic        clr;
    logic [15:0] alu;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  basic_cpu_ctrl_alu_if bus();

  basic_cpu_ctrl_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ms;       // model sequence count 0..7
  logic me;       // model E

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: instruction semantics in terms of opcode number and step count.
  task automatic drive(input logic rst_v, input logic inr_v, input logic clr_v,
                       input logic [15:0] ir_v, input logic r_v,
                       input logic [15:0] ac_v, input logic [15:0] dr_v,
                       input logic [7:0] inpr_v);
    exp_t x;
    int   op;
    bit   en, ind, regref, ioref;
    bit   is_and, is_add, is_lda, is_cma, is_cir, is_cil, is_inp;
    int   total;
    logic ne;
    rst = rst_v; bus.sc_inr = inr_v; bus.sc_clr = clr_v; bus.ir = ir_v;
    bus.r = r_v; bus.ac = ac_v; bus.dr = dr_v; bus.inpr = inpr_v;
`ifdef INTERRUPT_GATE_EN
    en = !r_v;
`else
    en = 1'b1;
`endif
    op     = int'(ir_v[14:12]);
    ind    = ir_v[15];
    regref = (op == 7) && !ind && (ms == 3);
    ioref  = (op == 7) &&  ind && (ms == 3);
    is_and = (op == 0) && (ms == 5);
    is_add = (op == 1) && (ms == 5);
    is_lda = (op == 2) && (ms == 5);
    is_cma = regref && ir_v[9];
    is_cir = regref && ir_v[7];
    is_cil = regref && ir_v[6];
    is_inp = ioref && ir_v[11];
    total  = int'(ac_v) + int'(dr_v);

    x.s   = 3'(ms);
    x.t   = 8'(1 << ms);
    x.d   = 8'(1 << op);
    x.i   = ind;
    x.clr = en && regref && ir_v[11];
    x.inr = en && regref && ir_v[5];
    x.ld  = en && (is_and || is_add || is_lda || is_cma || is_cir || is_cil || is_inp);
    if      (is_and) x.alu = ac_v & dr_v;
    else if (is_add) x.alu = 16'(total % 65536);
    else if (is_lda) x.alu = dr_v;
    else if (is_cma) x.alu = ~ac_v;
    else if (is_cir) x.alu = {me, ac_v[15:1]};
    else if (is_cil) x.alu = {ac_v[14:0], me};
    else if (is_inp) x.alu = {ac_v[15:8], inpr_v};
    else             x.alu = ac_v;
    x.e = me;
    q.push_back(x);

    ne = me;
    if (en) begin
      if      (is_add)              ne = (total >= 65536);
      else if (regref && ir_v[10])  ne = 1'b0;
      else if (regref && ir_v[8])   ne = ~me;
      else if (is_cir)              ne = ac_v[0];
      else if (is_cil)              ne = ac_v[15];
    end
    if (rst_v)       begin ms = 0; ne = 1'b0; end
    else if (clr_v)  ms = 0;
    else if (inr_v)  ms = (ms + 1) % 8;
    me = ne;

    @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int k, input logic r_v);
    drive(1'b0, 1'b0, 1'b1, 16'h0000, r_v, 16'h0000, 16'h0000, 8'h00);
    for (int n = 0; n < k; n++)
      drive(1'b0, 1'b1, 1'b0, 16'h0000, r_v, 16'h0000, 16'h0000, 8'h00);
  endtask

  // Monitor: outputs are combinational, so each cycle presents one result.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      check("s",       16'(bus.s),      16'(x.s));
      check("t",       16'(bus.t),      16'(x.t));
      check("d",       16'(bus.d),      16'(x.d));
      check("i",       16'(bus.i),      16'(x.i));
      check("ac_ld",   16'(bus.ac_ld),  16'(x.ld));
      check("ac_inr",  16'(bus.ac_inr), 16'(x.inr));
      check("ac_clr",  16'(bus.ac_clr), 16'(x.clr));
      check("alu_out", bus.alu_out,     x.alu);
      check("e",       16'(bus.e),      16'(x.e));
    end
  end

  initial begin
    logic [15:0] ir_r;
    int          wait_cnt;
    rst = 1'b1; bus.sc_inr = 1'b0; bus.sc_clr = 1'b0; bus.ir = 16'h0000;
    bus.r = 1'b0; bus.ac = 16'h0000; bus.dr = 16'h0000; bus.inpr = 8'h00;
    @(posedge clk);
    #1;
    ms = 0; me = 1'b0;

    // Reset state, then counting through wrap, then clear beating increment.
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 8'h00);
    for (int n = 0; n < 9; n++)
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 8'h00);

    // ADD with carry out.
    step_to(5, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 16'hFFFF, 16'h0001, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 8'h00);

    // CLA, INC, CIR, CIL (CLE first so E starts at 0), INP.
    step_to(3, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h7800, 1'b0, 16'h1111, 16'h0000, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 16'h7020, 1'b0, 16'h1111, 16'h0000, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 16'h7400, 1'b0, 16'h1111, 16'h0000, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 16'h7080, 1'b0, 16'h0003, 16'h0000, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 16'h7400, 1'b0, 16'h0000, 16'h0000, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 16'h7040, 1'b0, 16'h8000, 16'h0000, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 16'h7100, 1'b0, 16'h0000, 16'h0000, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 16'hF800, 1'b0, 16'hAB00, 16'h0000, 8'h5C);

    // AND with r high then low (gated only in the INTERRUPT_GATE_EN build).
    step_to(5, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hF0F0, 16'h3C3C, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hF0F0, 16'h3C3C, 8'h00);

    // Random stimulus, biased towards register-reference / IO at T3.
    for (int n = 0; n < 600; n++) begin
      ir_r = 16'($urandom);
      if ($urandom_range(0, 1) == 0) ir_r[14:12] = 3'd7;
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) == 0), ir_r, ($urandom_range(0, 3) == 0),
            16'($urandom), 16'($urandom), 8'($urandom));
    end

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
